// File: rtl/video_timing_gen_if.sv
// Video timing bundle: enable/lock requests in, counters and decoded strobes out.
// master = the generator, slave = a consumer (motion/mixing logic or a bench).
interface video_timing_gen_if #(
  parameter int unsigned CNT_W = 9
);
  logic             ce;
  logic             frame_lock;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             hsync;
  logic             vsync;
  logic             csync;
  logic             hblank;
  logic             vblank;
  logic             line_end;
  logic             frame_end;

  modport master (
    input  ce, frame_lock,
    output hcnt, vcnt, hsync, vsync, csync, hblank, vblank, line_end, frame_end
  );

  modport slave (
    output ce, frame_lock,
    input  hcnt, vcnt, hsync, vsync, csync, hblank, vblank, line_end, frame_end
  );
endinterface

// File: rtl/video_timing_gen.sv
// Configurable H/V video timing generator with registered sync/blank decodes
// and a genlock-style frame restart applied at the next line boundary.
module video_timing_gen #(
  parameter int unsigned CNT_W       = 9,
  parameter int unsigned H_TOTAL     = 455,
  parameter int unsigned HBLANK_END  = 80,
  parameter int unsigned HSYNC_START = 32,
  parameter int unsigned HSYNC_END   = 64,
  parameter int unsigned V_TOTAL     = 262,
  parameter int unsigned VBLANK_END  = 16,
  parameter int unsigned VSYNC_START = 4,
  parameter int unsigned VSYNC_END   = 8
) (
  input  logic                clk7_159,
  input  logic                hreset,
  video_timing_gen_if.master  vid
);

  localparam logic [CNT_W-1:0] HLast = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VLast = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] One   = CNT_W'(1);

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             lock_q, lock_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             csync_q, csync_d;
  logic             hblank_q, hblank_d;
  logic             vblank_q, vblank_d;
  logic             h_wrap;

  // Half-open [lo, hi) compare done in 32 bits so a bound of 2^CNT_W is not truncated.
  function automatic logic in_range(logic [CNT_W-1:0] c, int unsigned lo, int unsigned hi);
    return (32'(c) >= lo) && (32'(c) < hi);
  endfunction

  assign h_wrap = (hcnt_q == HLast);

  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    lock_d = lock_q | vid.frame_lock;
    if (vid.ce) begin
      if (h_wrap) begin
        hcnt_d = '0;
        lock_d = 1'b0;
        if (lock_q || vid.frame_lock || (vcnt_q == VLast)) begin
          vcnt_d = '0;
        end else begin
          vcnt_d = vcnt_q + One;
        end
      end else begin
        hcnt_d = hcnt_q + One;
      end
    end
  end

  // Decodes look at next-state counts so they line up with the registered counters.
  always_comb begin
    hsync_d  = in_range(hcnt_d, HSYNC_START, HSYNC_END);
    vsync_d  = in_range(vcnt_d, VSYNC_START, VSYNC_END);
    csync_d  = hsync_d ^ vsync_d;
    hblank_d = 32'(hcnt_d) < HBLANK_END;
    vblank_d = 32'(vcnt_d) < VBLANK_END;
  end

  always_ff @(posedge clk7_159 or posedge hreset) begin
    if (hreset) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      lock_q   <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      csync_q  <= 1'b0;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
    end else begin
      hcnt_q   <= hcnt_d;
      vcnt_q   <= vcnt_d;
      lock_q   <= lock_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      csync_q  <= csync_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
    end
  end

  assign vid.hcnt      = hcnt_q;
  assign vid.vcnt      = vcnt_q;
  assign vid.hsync     = hsync_q;
  assign vid.vsync     = vsync_q;
  assign vid.csync     = csync_q;
  assign vid.hblank    = hblank_q;
  assign vid.vblank    = vblank_q;
  // Strobes are data-path enables only; never use them as clocks.
  assign vid.line_end  = vid.ce & h_wrap;
  assign vid.frame_end = vid.ce & h_wrap & (vcnt_q == VLast);

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: stimulus pushes expected outputs from a count-based model,
// a monitor pops and compares half a cycle later for a default and a small DUT.
module tb_video_timing_gen;

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] v;
    logic       hs;
    logic       vs;
    logic       cs;
    logic       hb;
    logic       vb;
    logic       le;
    logic       fe;
  } obs_t;

  typedef struct {
    int h;
    int v;
    bit lk;
  } mst_t;

  logic clk7_159 = 1'b0;
  logic hreset   = 1'b1;
  logic ce       = 1'b0;
  logic frame_lock = 1'b0;

  int errors = 0;
  int checks = 0;

  obs_t qa[$];
  obs_t qb[$];
  mst_t sa = '{h: 0, v: 0, lk: 1'b0};
  mst_t sb = '{h: 0, v: 0, lk: 1'b0};

  video_timing_gen_if #(.CNT_W(9)) vif_a ();
  video_timing_gen_if #(.CNT_W(4)) vif_b ();

  assign vif_a.ce         = ce;
  assign vif_a.frame_lock = frame_lock;
  assign vif_b.ce         = ce;
  assign vif_b.frame_lock = frame_lock;

  video_timing_gen dut_a (
    .clk7_159 (clk7_159),
    .hreset   (hreset),
    .vid      (vif_a.master)
  );

  video_timing_gen #(
    .CNT_W(4), .H_TOTAL(16), .HBLANK_END(3), .HSYNC_START(5), .HSYNC_END(9),
    .V_TOTAL(4), .VBLANK_END(1), .VSYNC_START(2), .VSYNC_END(3)
  ) dut_b (
    .clk7_159 (clk7_159),
    .hreset   (hreset),
    .vid      (vif_b.master)
  );

  always #5 clk7_159 = ~clk7_159;

  // Outputs visible during a cycle as a pure function of the current counts.
  function automatic obs_t expect_obs(mst_t s, bit c, int ht, int vt, int hbe, int hss,
                                      int hse, int vbe, int vss, int vse);
    obs_t o;
    o.h  = 9'(s.h);
    o.v  = 9'(s.v);
    o.hs = (s.h >= hss) && (s.h < hse);
    o.vs = (s.v >= vss) && (s.v < vse);
    o.cs = o.hs ^ o.vs;
    o.hb = s.h < hbe;
    o.vb = s.v < vbe;
    o.le = c && (s.h == ht - 1);
    o.fe = o.le && (s.v == vt - 1);
    return o;
  endfunction

  function automatic mst_t advance(mst_t s, bit c, bit f, int ht, int vt);
    mst_t n = s;
    n.lk = s.lk | f;
    if (c) begin
      if (s.h == ht - 1) begin
        n.h  = 0;
        n.v  = (n.lk || s.v == vt - 1) ? 0 : s.v + 1;
        n.lk = 1'b0;
      end else begin
        n.h = s.h + 1;
      end
    end
    return n;
  endfunction

  task automatic step(input bit c, input bit f, input bit r);
    @(negedge clk7_159);
    ce         = c;
    frame_lock = f;
    hreset     = r;
    if (r) begin
      sa = '{h: 0, v: 0, lk: 1'b0};
      sb = '{h: 0, v: 0, lk: 1'b0};
    end
    qa.push_back(expect_obs(sa, c, 455, 262, 80, 32, 64, 16, 4, 8));
    qb.push_back(expect_obs(sb, c, 16, 4, 3, 5, 9, 1, 2, 3));
    if (!r) begin
      sa = advance(sa, c, f, 455, 262);
      sb = advance(sb, c, f, 16, 4);
    end
  endtask

  task automatic compare(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got h=%0d v=%0d hs,vs,cs,hb,vb,le,fe=%b expected h=%0d v=%0d %b",
               name, $time, act.h, act.v, act[6:0], exp.h, exp.v, exp[6:0]);
    end
  endtask

  // Monitor: every cycle the DUT presents a fresh set of outputs.
  initial begin
    obs_t ea, eb, aa, ab;
    forever begin
      @(negedge clk7_159);
      #1;
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        aa = {vif_a.hcnt, vif_a.vcnt, vif_a.hsync, vif_a.vsync, vif_a.csync, vif_a.hblank,
              vif_a.vblank, vif_a.line_end, vif_a.frame_end};
        compare("dut_a", aa, ea);
      end
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        ab = {5'b0, vif_b.hcnt, 5'b0, vif_b.vcnt, vif_b.hsync, vif_b.vsync, vif_b.csync,
              vif_b.hblank, vif_b.vblank, vif_b.line_end, vif_b.frame_end};
        compare("dut_b", ab, eb);
      end
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    // One full default line plus a few cycles into the next.
    for (int i = 0; i < 460; i++) step(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (sa.h != 100 && guard < 1000) begin step(1'b1, 1'b0, 1'b0); guard++; end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    // Mid-line reset at vcnt=20, hcnt=300.
    guard = 0;
    while (!(sa.v == 20 && sa.h == 300) && guard < 20000) begin
      step(1'b1, 1'b0, 1'b0); guard++;
    end
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    // Lock pulse mid-frame, then one exactly on the wrap cycle.
    guard = 0;
    while (!(sa.v == 50 && sa.h == 200) && guard < 30000) begin
      step(1'b1, 1'b0, 1'b0); guard++;
    end
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (sa.h != 454 && guard < 1000) begin step(1'b1, 1'b0, 1'b0); guard++; end
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
    // Randomized enable, lock pulses and occasional resets.
    for (int i = 0; i < 15000; i++) begin
      step($urandom_range(3, 0) != 0, $urandom_range(199, 0) == 0,
           $urandom_range(2999, 0) == 0);
    end
    @(negedge clk7_159);
    #2;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending entries, expected 0/0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
